// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the decode stage.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package md_pkg;

  localparam int MD_OP_W           = 4;
  localparam int MD_CNT_W          = 4;
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MADD  = 4'd7;
  localparam md_op_t MD_MADDU = 4'd8;
  localparam md_op_t MD_MSUB  = 4'd9;
  localparam md_op_t MD_MSUBU = 4'd10;

  typedef enum logic {
    MD_ST_IDLE = 1'b0,
    MD_ST_BUSY = 1'b1
  } md_state_e;

  // Collapse unsupported or reserved encodings onto MD_NONE.
  function automatic md_op_t md_decode(input md_op_t op);
    md_op_t d;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: d = op;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU:                d = op;
`endif
      default:                                             d = MD_NONE;
    endcase
    return d;
  endfunction

  // Ops that occupy the unit for several cycles (expects a decoded op).
  function automatic logic md_is_long(input md_op_t op);
    return (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                       MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU});
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational datapath: product, quotient/remainder and (optionally)
// HI/LO accumulate. Result is {hi_new, lo_new}.
// Optional feature macro: MD_MADD_EN.
module md_core
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  input  logic [31:0]        hi,
  input  logic [31:0]        lo,
  output logic [63:0]        result,
  output logic               div_zero
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_n, div_d, q_raw, r_raw, q_fix, r_fix;
  logic        is_sdiv;

  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // One unsigned divider serves both flavours; signed operands go in as magnitudes.
  assign is_sdiv = (op == MD_DIV);
  assign abs_a   = src_a[31] ? (~src_a + 32'd1) : src_a;
  assign abs_b   = src_b[31] ? (~src_b + 32'd1) : src_b;
  assign div_n   = is_sdiv ? abs_a : src_a;
  assign div_d   = is_sdiv ? abs_b : src_b;
  assign q_raw   = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
  assign r_raw   = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign q_fix   = (is_sdiv && (src_a[31] ^ src_b[31])) ? (~q_raw + 32'd1) : q_raw;
  assign r_fix   = (is_sdiv && src_a[31]) ? (~r_raw + 32'd1) : r_raw;

  assign div_zero = (op inside {MD_DIV, MD_DIVU}) && (src_b == 32'd0);

`ifdef MD_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`else
  logic unused_hilo;
  assign unused_hilo = ^{hi, lo};
`endif

  // Select the 64-bit result for the requested operation.
  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV,
      MD_DIVU:  result = {r_fix, q_fix};
`ifdef MD_MADD_EN
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
      MD_MSUB:  result = acc - prod_s;
      MD_MSUBU: result = acc - prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, runs long ops for a fixed cycle count
// and commits the latched result when the down-counter reaches terminal count.
// Optional feature macro: MD_MADD_EN.
//
// state      | meaning
// -----------+------------------------------------------------------
// MD_ST_IDLE | no op in flight; MTHI/MTLO and long ops may be accepted
// MD_ST_BUSY | long op in flight; counter runs, commit at count == 1
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               md_en,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               kill,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           state, state_nxt;
  logic [MD_CNT_W-1:0] cnt;
  logic [63:0]         pend;
  logic                pend_skip;
  logic [31:0]         hi_q, lo_q;
  logic [63:0]         core_res;
  logic                core_dz;
  md_op_t              op_dec;
  logic                accept, accept_long, term, commit;

  md_core u_core (
    .op       (op_dec),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi       (hi_q),
    .lo       (lo_q),
    .result   (core_res),
    .div_zero (core_dz)
  );

  assign op_dec      = md_decode(md_op);
  assign accept      = md_en && !kill && (state == MD_ST_IDLE) && (op_dec != MD_NONE);
  assign accept_long = accept && md_is_long(op_dec);
  assign term        = (state == MD_ST_BUSY) && (cnt == MD_CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      MD_ST_IDLE: if (accept_long) state_nxt = MD_ST_BUSY;
      MD_ST_BUSY: if (term)        state_nxt = MD_ST_IDLE;
      default:                     state_nxt = MD_ST_IDLE;
    endcase
  end

  // Outputs derived from state; commit is suppressed for divide-by-zero.
  always_comb begin
    busy   = (state == MD_ST_BUSY);
    commit = term && !pend_skip;
  end

  // Down-counter: loaded on accept, decremented while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (accept_long)
      cnt <= (op_dec inside {MD_DIV, MD_DIVU}) ? DIV_LD : MULT_LD;
    else if (state == MD_ST_BUSY)
      cnt <= cnt - MD_CNT_W'(1);
  end

  // Pending result captured at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_skip <= 1'b0;
    end else if (accept_long) begin
      pend      <= core_res;
      pend_skip <= core_dz;
    end
  end

  // Architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= pend[63:32];
      lo_q <= pend[31:0];
    end else if (accept && op_dec == MD_MTHI) begin
      hi_q <= src_a;
    end else if (accept && op_dec == MD_MTLO) begin
      lo_q <= src_a;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
